motoro3_line_step_scheduler: RTL

- Sequences the line-calculation datapath, which is the PWM-length and sine-length calculators driven by lcStep.
- Walks lcStep through one electrical round (STEP_NUM steps).
- Holds each step for slLen PWM periods of plLen clocks each.
- Shadows the m3r_* configuration registers so a new PWM length takes effect only at a round boundary. Sits between the register file and the three-phase PWM generator.

---
 rtl/motoro3_line_step_scheduler.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/motoro3_line_step_scheduler.sv
// motoro3_line_step_scheduler
// Sequences the line-calculation datapath. It walks lcStep through one
// electrical round of STEP_NUM steps and holds each step for slLen PWM
// periods of plLen clocks each. The m3r_* configuration registers are
// shadowed, so a new PWM length takes effect only at a round boundary.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   start, stop      start pulse (honoured only when idle) / stop pulse
//                    (the current round finishes, then the block idles)
//   m3r_pwmLenWant   requested PWM length from the register file
//   m3r_pwmMinMask   minimum-pulse mask from the register file
//   plLen, slLen     PWM period length and PWM periods per step from the
//                    calculators, valid SETTLE_CYC clocks after their inputs move
//   lcStep           current step index to the calculators
//   pwmLenUsed       shadowed m3r_pwmLenWant
//   pwmMinMaskUsed   shadowed m3r_pwmMinMask
//   pwmStrobe        one-clock pulse at the start of every PWM period
//   stepStrobe       one-clock pulse on the first RUN clock of every step
//   roundDone        one-clock pulse on the final RUN clock of a round
//   busy             high whenever the block is not idle
//   lenErr           sticky flag: a sampled plLen or slLen was zero
module motoro3_line_step_scheduler #(
  parameter int unsigned STEP_NUM   = 12,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [11:0] m3r_pwmLenWant,
  input  logic [11:0] m3r_pwmMinMask,
  input  logic [15:0] plLen,
  input  logic [15:0] slLen,
  output logic [3:0]  lcStep,
  output logic [11:0] pwmLenUsed,
  output logic [11:0] pwmMinMaskUsed,
  output logic        pwmStrobe,
  output logic        stepStrobe,
  output logic        roundDone,
  output logic        busy,
  output logic        lenErr
);

  localparam int unsigned STEP_W = 4;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CFG_W  = 12;
  localparam int unsigned SET_W  = 4;

  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(STEP_NUM - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]        state,      state_nxt;
  logic [SET_W-1:0]  settle_cnt, settle_cnt_nxt;
  logic [LEN_W-1:0]  pwm_cnt,    pwm_cnt_nxt;
  logic [LEN_W-1:0]  sl_cnt,     sl_cnt_nxt;
  logic [LEN_W-1:0]  pl_q,       pl_q_nxt;
  logic [LEN_W-1:0]  sl_q,       sl_q_nxt;
  logic              stopping,   stopping_nxt;

  logic [STEP_W-1:0] lc_step_nxt;
  logic [CFG_W-1:0]  len_used_nxt;
  logic [CFG_W-1:0]  mask_used_nxt;
  logic              len_err_nxt;
  logic              pwm_strobe_nxt;
  logic              step_strobe_nxt;
  logic              round_done_nxt;
  logic              busy_nxt;

  logic              period_end;
  logic              step_end;

  // Terminal counts of the running PWM period and of the step.
  assign period_end = (pwm_cnt == (pl_q - LEN_W'(1)));
  assign step_end   = period_end && (sl_cnt == (sl_q - LEN_W'(1)));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    pwm_cnt_nxt    = pwm_cnt;
    sl_cnt_nxt     = sl_cnt;
    pl_q_nxt       = pl_q;
    sl_q_nxt       = sl_q;
    stopping_nxt   = stopping;
    lc_step_nxt    = lcStep;
    len_used_nxt   = pwmLenUsed;
    mask_used_nxt  = pwmMinMaskUsed;
    len_err_nxt    = lenErr;

    // A stop while busy is remembered until the round boundary.
    if ((state != S_IDLE) && stop) begin
      stopping_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        // start wins over a simultaneous stop, which still limits us to one round.
        if (start) begin
          state_nxt    = S_LOAD;
          len_err_nxt  = 1'b0;
          stopping_nxt = stop;
        end
      end

      S_LOAD: begin
        len_used_nxt   = m3r_pwmLenWant;
        mask_used_nxt  = m3r_pwmMinMask;
        lc_step_nxt    = '0;
        settle_cnt_nxt = '0;
        state_nxt      = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          // Freeze lengths for the whole step; zero is forced to 1 to keep counting sane.
          pl_q_nxt = (plLen == '0) ? LEN_W'(1) : plLen;
          sl_q_nxt = (slLen == '0) ? LEN_W'(1) : slLen;
          if ((plLen == '0) || (slLen == '0)) begin
            len_err_nxt = 1'b1;
          end
          pwm_cnt_nxt = '0;
          sl_cnt_nxt  = '0;
          state_nxt   = S_RUN;
        end else begin
          settle_cnt_nxt = settle_cnt + SET_W'(1);
        end
      end

      S_RUN: begin
        if (period_end) begin
          pwm_cnt_nxt = '0;
          if (step_end) begin
            sl_cnt_nxt = '0;
            if (lcStep != LAST_STEP) begin
              lc_step_nxt    = lcStep + STEP_W'(1);
              settle_cnt_nxt = '0;
              state_nxt      = S_SETTLE;
            end else if (stopping || stop) begin
              lc_step_nxt  = '0;
              stopping_nxt = 1'b0;
              state_nxt    = S_IDLE;
            end else begin
              state_nxt = S_LOAD;
            end
          end else begin
            sl_cnt_nxt = sl_cnt + LEN_W'(1);
          end
        end else begin
          pwm_cnt_nxt = pwm_cnt + LEN_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Strobes are computed from the upcoming clock so they line up with it once registered.
    pwm_strobe_nxt  = (state_nxt == S_RUN) && (pwm_cnt_nxt == '0);
    step_strobe_nxt = (state_nxt == S_RUN) && (state != S_RUN);
    round_done_nxt  = (state_nxt == S_RUN) &&
                      (lc_step_nxt == LAST_STEP) &&
                      (pwm_cnt_nxt == (pl_q_nxt - LEN_W'(1))) &&
                      (sl_cnt_nxt == (sl_q_nxt - LEN_W'(1)));
    busy_nxt        = (state_nxt != S_IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      pwm_cnt        <= '0;
      sl_cnt         <= '0;
      pl_q           <= '0;
      sl_q           <= '0;
      stopping       <= 1'b0;
      lcStep         <= '0;
      pwmLenUsed     <= '0;
      pwmMinMaskUsed <= '0;
      pwmStrobe      <= 1'b0;
      stepStrobe     <= 1'b0;
      roundDone      <= 1'b0;
      busy           <= 1'b0;
      lenErr         <= 1'b0;
    end else begin
      state          <= state_nxt;
      settle_cnt     <= settle_cnt_nxt;
      pwm_cnt        <= pwm_cnt_nxt;
      sl_cnt         <= sl_cnt_nxt;
      pl_q           <= pl_q_nxt;
      sl_q           <= sl_q_nxt;
      stopping       <= stopping_nxt;
      lcStep         <= lc_step_nxt;
      pwmLenUsed     <= len_used_nxt;
      pwmMinMaskUsed <= mask_used_nxt;
      pwmStrobe      <= pwm_strobe_nxt;
      stepStrobe     <= step_strobe_nxt;
      roundDone      <= round_done_nxt;
      busy           <= busy_nxt;
      lenErr         <= len_err_nxt;
    end
  end

endmodule
